// File: rtl/marker_pkg.sv
// Shared definitions for the marker scheduler: generator marker-type codes,
// the scheduler FSM state encoding and a helper for sequence-carrying types.
package marker_pkg;

  localparam logic [3:0] MT_CLOCK        = 4'd0;
  localparam logic [3:0] MT_EVENT        = 4'd1;
  localparam logic [3:0] MT_LOOPBACK     = 4'd2;
  localparam logic [3:0] MT_RETRANS      = 4'd3;
  localparam logic [3:0] MT_DIAG         = 4'd4;
  localparam logic [3:0] MT_TIMEOUT      = 4'd5;
  localparam logic [3:0] MT_DCSREQ       = 4'd6;
  localparam logic [3:0] MT_UNDEF        = 4'd7;
  localparam logic [3:0] MT_BAD_RETRANS  = 4'd11;
  localparam logic [3:0] MT_MISS_RETRANS = 4'd14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GUARD = 2'd2
  } state_t;

  // Only the retransmit-family markers carry a sequence number on the wire.
  function automatic logic usesSeq(input logic [3:0] markerType);
    return (markerType == MT_RETRANS) || (markerType == MT_BAD_RETRANS) ||
           (markerType == MT_MISS_RETRANS);
  endfunction

endpackage

// File: rtl/marker_scheduler_if.sv
// Request, handshake and generator-facing signals of the marker scheduler.
// The slave modport is the scheduler; the master modport is whoever drives requests.
interface marker_scheduler_if #(
  parameter int PER_W = 16
);
  logic             ENABLE;
  logic [PER_W-1:0] CLKMRK_PERIOD;
  logic             RETX_VALID;
  logic [3:0]       RETX_SEQ;
  logic             RETX_READY;
  logic             REQ_VALID;
  logic [3:0]       REQ_TYPE;
  logic [3:0]       REQ_SEQ;
  logic             REQ_READY;
  logic             START;
  logic [3:0]       MARKER_TYPE;
  logic [3:0]       SEQ_NUM;
  logic             BUSY;
  logic [7:0]       CLKMRK_MISSED;
  logic [15:0]      MARKER_COUNT;

  modport master (
    output ENABLE, CLKMRK_PERIOD, RETX_VALID, RETX_SEQ, REQ_VALID, REQ_TYPE, REQ_SEQ,
    input  RETX_READY, REQ_READY, START, MARKER_TYPE, SEQ_NUM, BUSY,
           CLKMRK_MISSED, MARKER_COUNT
  );

  modport slave (
    input  ENABLE, CLKMRK_PERIOD, RETX_VALID, RETX_SEQ, REQ_VALID, REQ_TYPE, REQ_SEQ,
    output RETX_READY, REQ_READY, START, MARKER_TYPE, SEQ_NUM, BUSY,
           CLKMRK_MISSED, MARKER_COUNT
  );
endinterface

// File: rtl/marker_period_timer.sv
// Periodic clock-marker timer: counts 0..period-1, raises a pending flag at
// terminal count and counts (saturating) periods that expire while still pending.
module marker_period_timer #(
  parameter int PER_W = 16
) (
  input  logic             XCVR_CLK,
  input  logic             XCVR_RESETN,
  input  logic             i_enable,
  input  logic [PER_W-1:0] i_period,
  input  logic             i_grantPending,
  output logic             o_pending,
  output logic [7:0]       o_missed
);

  logic [PER_W-1:0] r_cnt;
  logic             r_pending;
  logic [7:0]       r_missed;
  logic             w_terminal;

  // Compare with >= so a period shrunk below the running count still terminates.
  assign w_terminal = (r_cnt >= (i_period - PER_W'(1)));

  // Counter, pending flag and missed-period counter; a grant in the terminal cycle leaves pending set.
  always_ff @(posedge XCVR_CLK or negedge XCVR_RESETN) begin
    if (!XCVR_RESETN) begin
      r_cnt     <= '0;
      r_pending <= 1'b0;
      r_missed  <= '0;
    end else if (!i_enable) begin
      r_cnt     <= '0;
      r_pending <= 1'b0;
    end else if (i_period == '0) begin
      r_cnt <= '0;
      if (i_grantPending) r_pending <= 1'b0;
    end else if (w_terminal) begin
      r_cnt     <= '0;
      r_pending <= 1'b1;
      if (r_pending && !i_grantPending && (r_missed != 8'hFF)) r_missed <= r_missed + 8'd1;
    end else begin
      r_cnt <= r_cnt + PER_W'(1);
      if (i_grantPending) r_pending <= 1'b0;
    end
  end

  assign o_pending = r_pending;
  assign o_missed  = r_missed;

endmodule

// File: rtl/marker_scheduler.sv
// Marker scheduler: arbitrates clock-marker, retransmit and generic requests
// onto the marker generator and enforces the START spacing it needs.
module marker_scheduler
  import marker_pkg::*;
#(
  parameter int START_WIDTH  = 4,
  parameter int GUARD_CYCLES = 16,
  parameter int PER_W        = 16
) (
  input logic               XCVR_CLK,
  input logic               XCVR_RESETN,
  marker_scheduler_if.slave bus
);

  localparam int GW = $clog2(GUARD_CYCLES + 1);
  localparam logic [GW-1:0] ISSUE_LAST = GW'(START_WIDTH - 1);
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);

  state_t      r_state;
  state_t      w_nextState;
  logic [GW-1:0] r_guardCnt;
  logic [3:0]  r_markerType;
  logic [3:0]  r_seqNum;
  logic [15:0] r_markerCount;
  logic        w_idle;
  logic        w_clkPending;
  logic        w_grantClk;
  logic        w_grantRetx;
  logic        w_grantReq;
  logic        w_grant;
  logic [3:0]  w_grantType;
  logic [3:0]  w_grantSeq;
  logic [7:0]  w_missed;

  marker_period_timer #(.PER_W(PER_W)) u_timer (
    .XCVR_CLK       (XCVR_CLK),
    .XCVR_RESETN    (XCVR_RESETN),
    .i_enable       (bus.ENABLE),
    .i_period       (bus.CLKMRK_PERIOD),
    .i_grantPending (w_grantClk),
    .o_pending      (w_clkPending),
    .o_missed       (w_missed)
  );

  assign w_idle  = (r_state == ST_IDLE);
  assign w_grant = w_grantClk || w_grantRetx || w_grantReq;

  // Fixed-priority arbiter: pending clock marker, then retransmit, then generic request.
  always_comb begin
    w_grantClk  = 1'b0;
    w_grantRetx = 1'b0;
    w_grantReq  = 1'b0;
    w_grantType = MT_CLOCK;
    w_grantSeq  = 4'd0;
    if (w_idle && bus.ENABLE) begin
      if (w_clkPending) begin
        w_grantClk = 1'b1;
      end else if (bus.RETX_VALID) begin
        w_grantRetx = 1'b1;
        w_grantType = MT_RETRANS;
        w_grantSeq  = bus.RETX_SEQ;
      end else if (bus.REQ_VALID) begin
        w_grantReq  = 1'b1;
        w_grantType = bus.REQ_TYPE;
        w_grantSeq  = usesSeq(bus.REQ_TYPE) ? bus.REQ_SEQ : 4'd0;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge XCVR_CLK or negedge XCVR_RESETN) begin
    if (!XCVR_RESETN) r_state <= ST_IDLE;
    else              r_state <= w_nextState;
  end

  // Next state: a grant starts ISSUE; the shared counter times both ISSUE and GUARD from START rise.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:  if (w_grant) w_nextState = ST_ISSUE;
      ST_ISSUE: if (r_guardCnt == ISSUE_LAST) w_nextState = ST_GUARD;
      ST_GUARD: if (r_guardCnt == GUARD_LAST) w_nextState = ST_IDLE;
      default:  w_nextState = ST_IDLE;
    endcase
  end

  // Cycles since START rise; restarts at each grant.
  always_ff @(posedge XCVR_CLK or negedge XCVR_RESETN) begin
    if (!XCVR_RESETN)        r_guardCnt <= '0;
    else if (w_grant)        r_guardCnt <= '0;
    else if (!w_idle)        r_guardCnt <= r_guardCnt + GW'(1);
  end

  // Marker fields are captured at grant and held until the next one; the count steps with START rise.
  always_ff @(posedge XCVR_CLK or negedge XCVR_RESETN) begin
    if (!XCVR_RESETN) begin
      r_markerType  <= 4'd0;
      r_seqNum      <= 4'd0;
      r_markerCount <= 16'd0;
    end else if (w_grant) begin
      r_markerType  <= w_grantType;
      r_seqNum      <= w_grantSeq;
      r_markerCount <= r_markerCount + 16'd1;
    end
  end

  assign bus.RETX_READY    = w_grantRetx;
  assign bus.REQ_READY     = w_grantReq;
  assign bus.START         = (r_state == ST_ISSUE);
  assign bus.BUSY          = !w_idle;
  assign bus.MARKER_TYPE   = r_markerType;
  assign bus.SEQ_NUM       = r_seqNum;
  assign bus.CLKMRK_MISSED = w_missed;
  assign bus.MARKER_COUNT  = r_markerCount;

endmodule
